// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone classic arbiter: round-robin on ties, grant held for a whole cycle.
// Optional slave watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; slave bus driven to zero; arbitration happens here
// GNT0  | master 0 owns the slave bus until m0_cyc_i drops
// GNT1  | master 1 owns the slave bus until m1_cyc_i drops

module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o,
    output logic        tmo_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       hold;
    logic       tmo_fire;

    // Every grant is entered from IDLE, so a release can never collide with a new grant.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    gnt_d   = 2'b01;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    gnt_d   = 2'b10;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o = gnt_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       hold_q, hold_d;
    logic       req_act;

    always_comb begin
        req_act = 1'b0;
        if (!hold_q) begin
            if (state_q == GNT0)      req_act = m0_cyc_i & m0_stb_i;
            else if (state_q == GNT1) req_act = m1_cyc_i & m1_stb_i;
        end
    end

    assign tmo_fire = req_act && (cnt_q == TMO_CNT);

    // Clearing on the firing cycle keeps the count from advancing past the limit.
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if ((state_d != state_q) || s_ack_i || tmo_fire) begin
            cnt_d = 8'd0;
        end else if (req_act) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (state_d == IDLE) begin
            hold_d = 1'b0;
        end else if (tmo_fire) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q  <= 8'd0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign hold  = hold_q;
    assign tmo_o = tmo_fire;
`else
    assign hold     = 1'b0;
    assign tmo_fire = 1'b0;
    assign tmo_o    = 1'b0;
`endif

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'b0000;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        m0_ack_o = 1'b0;
        m0_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'd0;
        unique case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~hold;
                s_stb_o  = m0_stb_i & ~hold;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = tmo_fire | s_ack_i;
                m0_dat_o = tmo_fire ? TIMEOUT_DATA : s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~hold;
                s_stb_o  = m1_stb_i & ~hold;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = tmo_fire | s_ack_i;
                m1_dat_o = tmo_fire ? TIMEOUT_DATA : s_dat_i;
            end
            default: ;
        endcase
    end

endmodule
